// File: rtl/pp_column_loader.sv
// pp_column_loader: serially loads partial-product columns of a W x W multiplier, presents them flattened to a compressor, and captures the returned sum.
// Ports:
//    clk, rst        - rising-edge clock, asynchronous active-high reset
//    flush           - synchronous clear of columns, fill count and state (res_q untouched)
//    in_valid/ready  - beat handshake, in_bits carries one serial bit per column (2W-1 bits)
//    out_valid/ready - columns-full handshake, out_bus is the flattened column contents (W*W bits)
//    res_in          - compressor sum, captured into res_q on the output handshake
//    res_valid       - one-cycle pulse after res_q updates
//    fill_level      - number of beats accepted in the current load
module pp_column_loader #(
   parameter int W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*W-2:0]         in_bits,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W*W-1:0]         out_bus,
   input  logic [2*W:0]           res_in,
   output logic [2*W:0]           res_q,
   output logic                   res_valid,
   output logic [$clog2(W+1)-1:0] fill_level
);
   localparam int C  = 2 * W - 1;
   localparam int N  = W * W;
   localparam int FW = $clog2(W + 1);
   localparam logic [FW-1:0] LAST = FW'(W - 1);

   typedef enum logic {LOAD, FULL} state_t;

   function automatic int col_h(int i);
      return (i + 1 < C - i) ? i + 1 : C - i;
   endfunction

   function automatic int col_off(int i);
      int s = 0;
      for (int k = 0; k < i; k++) s += col_h(k);
      return s;
   endfunction

   state_t          state_q, state_d;
   logic [N-1:0]    col_q, col_d, col_sh;
   logic [FW-1:0]   fill_q, fill_d;
   logic [2*W:0]    res_d;
   logic            res_valid_q, res_valid_d;
   logic            accept, hs;

   assign accept     = in_valid & in_ready;
   assign hs         = out_valid & out_ready;
   assign out_bus    = col_q;
   assign fill_level = fill_q;
   assign res_valid  = res_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LOAD;
         col_q       <= '0;
         fill_q      <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         fill_q      <= fill_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush)
         state_d = LOAD;
      else if (state_q == LOAD && accept && fill_q == LAST)
         state_d = FULL;
      else if (state_q == FULL && out_ready)
         state_d = LOAD;
   end

   always_comb begin
      in_ready  = state_q == LOAD;
      out_valid = state_q == FULL;
   end

   // Each column is a shift register occupying bits off(i)..off(i)+h(i)-1; the new bit enters at the low end.
   always_comb begin
      col_sh = col_q;
      for (int i = 0; i < C; i++)
         for (int j = 0; j < W; j++)
            if (j == 0)
               col_sh[col_off(i)] = in_bits[i];
            else if (j < col_h(i))
               col_sh[col_off(i) + j] = col_q[col_off(i) + j - 1];
   end

   // flush wins over a simultaneous beat or handshake, both of which are dropped.
   always_comb begin
      col_d       = flush ? '0 : accept ? col_sh : col_q;
      fill_d      = flush ? '0 : hs ? '0 : accept ? fill_q + FW'(1) : fill_q;
      res_d       = (hs && !flush) ? res_in : res_q;
      res_valid_d = hs && !flush;
   end
endmodule

// File: tb/tb_pp_column_loader.sv
// tb_pp_column_loader: directed self-checking bench for pp_column_loader with W = 4.
module tb_pp_column_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_bits = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_bus;
   logic [8:0]  res_in = '0;
   logic [8:0]  res_q;
   logic        res_valid;
   logic [2:0]  fill_level;
   int          n_chk = 0;
   int          n_fail = 0;

   pp_column_loader #(.W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_bits(in_bits), .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus),
      .res_in(res_in), .res_q(res_q), .res_valid(res_valid), .fill_level(fill_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [6:0] b);
      in_valid = 1'b1;
      in_bits  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic handshake(input logic [8:0] r);
      out_ready = 1'b1;
      res_in    = r;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] held;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_bus", out_bus, 16'h0000);
      chk("rst_fill", fill_level, 0);
      chk("rst_res_q", res_q, 9'h000);
      chk("rst_res_valid", res_valid, 0);

      repeat (3) beat(7'h7F);
      chk("ones_3_out_valid", out_valid, 0);
      chk("ones_3_fill", fill_level, 3);
      beat(7'h7F);
      chk("ones_out_valid", out_valid, 1);
      chk("ones_out_bus", out_bus, 16'hFFFF);
      chk("ones_fill", fill_level, 4);
      chk("ones_in_ready", in_ready, 0);
      handshake(9'h000);

      beat(7'h08);
      repeat (3) beat(7'h00);
      chk("col3_out_bus", out_bus, 16'h0200);
      chk("col3_out_valid", out_valid, 1);
      handshake(9'h000);
      beat(7'h01);
      repeat (3) beat(7'h00);
      chk("col0_out_bus", out_bus, 16'h0000);
      handshake(9'h000);

      repeat (3) beat(7'h00);
      beat(7'h7F);
      chk("bit0_out_bus", out_bus, 16'hA44B);

      held = out_bus;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_bits = 7'(k * 19 + 5);
         tick();
         chk("hold_out_bus", out_bus, held);
         chk("hold_fill", fill_level, 4);
      end
      in_valid = 1'b0;
      handshake(9'h031);
      chk("hs_res_q", res_q, 9'h031);
      chk("hs_res_valid", res_valid, 1);
      chk("hs_fill", fill_level, 0);
      chk("hs_in_ready", in_ready, 1);
      tick();
      chk("hs_res_valid_pulse", res_valid, 0);
      chk("hs_out_bus_kept", out_bus, held);

      repeat (2) beat(7'h7F);
      flush = 1'b1;
      in_valid = 1'b1;
      in_bits = 7'h7F;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_fill", fill_level, 0);
      chk("flush_out_bus", out_bus, 16'h0000);
      chk("flush_res_q", res_q, 9'h031);

      repeat (4) beat(7'h7F);
      chk("flush_full", out_valid, 1);
      flush = 1'b1;
      out_ready = 1'b1;
      res_in = 9'h1AB;
      tick();
      flush = 1'b0;
      out_ready = 1'b0;
      chk("flushhs_res_valid", res_valid, 0);
      chk("flushhs_res_q", res_q, 9'h031);
      chk("flushhs_out_valid", out_valid, 0);
      chk("flushhs_out_bus", out_bus, 16'h0000);

      repeat (4) beat(7'h7F);
      handshake(9'h0F0);
      repeat (4) beat(7'h7F);
      chk("arst_pre_full", out_valid, 1);
      chk("arst_pre_res_q", res_q, 9'h0F0);
      rst = 1'b1;
      #2;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_bus", out_bus, 16'h0000);
      chk("arst_fill", fill_level, 0);
      chk("arst_res_q", res_q, 9'h000);
      tick();
      rst = 1'b0;
      repeat (4) beat(7'h55);
      chk("post_rst_out_valid", out_valid, 1);
      chk("post_rst_out_bus", out_bus, 16'h9C39);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
